md5_block_formatter: RTL and testbench

Accepts one plaintext candidate and its byte length from the MD5 controller and emits the fully padded 512-bit MD5 message block, one 32-bit word per beat, to the MD5 hashing core. It is the receiving end of the controller's guess interface and replaces ad-hoc padding at the core input. Padding follows RFC 1321: 0x80 marker, zero fill, 64-bit little-endian bit length. Only single-block messages are produced.

---
 rtl/md5_block_formatter_if.sv | 26 ++
 rtl/md5_block_formatter.sv | 103 ++++++++++
 tb/tb_md5_block_formatter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/md5_block_formatter_if.sv
// Guess-in / message-word-out handshake bundle for md5_block_formatter.
// slave is the formatter's view, master is the controller/core side.
interface md5_block_formatter_if #(
    parameter int MAX_BYTES = 16,
    parameter int WW        = $clog2(MAX_BYTES + 1)
);
    logic [8*MAX_BYTES-1:0] word_in;
    logic [WW-1:0]          word_in_width;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            m_word;
    logic [3:0]             m_index;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;

    modport slave (
        input  word_in, word_in_width, in_valid, m_ready,
        output in_ready, m_word, m_index, m_valid, m_last
    );

    modport master (
        output word_in, word_in_width, in_valid, m_ready,
        input  in_ready, m_word, m_index, m_valid, m_last
    );
endinterface

// File: rtl/md5_block_formatter.sv
// Turns one plaintext candidate into a single RFC 1321 padded 512-bit block,
// streamed to the hashing core as sixteen 32-bit little-endian words.
module md5_block_formatter #(
    parameter int MAX_BYTES = 16,
    parameter int WW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    md5_block_formatter_if.slave     bus,
    output logic                     width_err,
    output logic [15:0]              block_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                 state_q, state_d;
    logic                   up_q;
    logic [3:0]             idx_q;
    logic [8*MAX_BYTES-1:0] data_q;
    logic [WW-1:0]          n_q;
    logic                   accept, beat, over;
    logic [31:0]            word;

    assign over = bus.word_in_width > WW'(MAX_BYTES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        beat    = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid && up_q) begin
                accept  = 1'b1;
                state_d = EMIT;
            end
            EMIT: if (bus.m_ready) begin
                beat = 1'b1;
                if (idx_q == 4'd15) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // up_q keeps in_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_q        <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
            n_q         <= '0;
            width_err   <= 1'b0;
            block_count <= '0;
        end else begin
            up_q      <= 1'b1;
            width_err <= accept && over;
            if (accept) begin
                idx_q  <= '0;
                data_q <= bus.word_in;
                n_q    <= over ? WW'(MAX_BYTES) : bus.word_in_width;
            end else if (beat && idx_q != 4'd15) begin
                idx_q <= idx_q + 4'd1;
            end
            if (beat && idx_q == 4'd15) block_count <= block_count + 16'd1;
        end
    end

    // Byte k of the block: plaintext (first char in the top byte), 0x80, zeros,
    // then the 64-bit bit length little-endian in bytes 56..63.
    always_comb begin
        logic [6:0]             k, nn;
        logic [8*MAX_BYTES-1:0] sh;
        logic [63:0]            bitlen, lsh;
        logic [7:0]             b;
        word   = '0;
        k      = '0;
        sh     = '0;
        lsh    = '0;
        b      = '0;
        nn     = 7'(n_q);
        bitlen = 64'(n_q) << 3;
        for (int i = 0; i < 4; i++) begin
            k   = {1'b0, idx_q, 2'(i)};
            sh  = data_q >> {nn - k - 7'd1, 3'b000};
            lsh = bitlen >> {k - 7'd56, 3'b000};
            if (k < nn)          b = sh[7:0];
            else if (k == nn)    b = 8'h80;
            else if (k < 7'd56)  b = 8'h00;
            else                 b = lsh[7:0];
            word[8*i +: 8] = b;
        end
    end

    assign bus.in_ready = (state_q == IDLE) && up_q;
    assign bus.m_valid  = (state_q == EMIT);
    assign bus.m_index  = idx_q;
    assign bus.m_word   = bus.m_valid ? word : 32'h0;
    assign bus.m_last   = bus.m_valid && (idx_q == 4'd15);

endmodule

// File: tb/tb_md5_block_formatter.sv
// Directed bench for md5_block_formatter: padding content, handshake timing,
// stalls, length clamping and asynchronous reset mid-block.
module tb_md5_block_formatter;

    localparam int MB = 16;
    localparam logic [127:0] ALPHA = 128'h6162636465666768696a6b6c6d6e6f70;
    localparam logic [127:0] AKHA  = 128'h0000000000000000000000616b6861;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        width_err;
    logic [15:0] block_count;

    md5_block_formatter_if #(.MAX_BYTES(MB)) bus ();

    md5_block_formatter #(.MAX_BYTES(MB)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .width_err(width_err), .block_count(block_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int blocks = 0;

    logic [31:0] got [16];
    logic [31:0] exp_w [16];
    int beats, last_cyc, stab_err, ord_err, last_err, werr_cnt;

    task automatic send(input logic [127:0] w, input logic [4:0] n);
        bus.word_in       = w;
        bus.word_in_width = n;
        bus.in_valid      = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called in cycle t+1; records every accepted beat, leaves at the next idle cycle
    task automatic collect(input int mode);
        int cyc, stall;
        logic tog, tog_en, r, pv, pr;
        logic [31:0] pw;
        logic [3:0] pi;
        beats = 0; last_cyc = 0; stab_err = 0; ord_err = 0; last_err = 0; werr_cnt = 0;
        cyc = 1; stall = 0; tog = 1'b1; tog_en = 1'b0; pv = 1'b0; pr = 1'b1; pw = '0; pi = '0;
        for (int g = 0; g < 16; g++) got[g] = 32'hdeadbeef;
        while (beats < 16 && cyc < 200) begin
            if (mode == 0) r = 1'b1;
            else if (!tog_en && bus.m_index == 4'd7) begin
                r = 1'b0; stall++;
                if (stall == 5) tog_en = 1'b1;
            end else if (tog_en) begin
                r = tog; tog = ~tog;
            end else r = 1'b1;
            bus.m_ready  = r;
            bus.in_valid = (mode == 1) && (cyc % 2 == 0);
            if (mode == 1 && (cyc % 2 == 0)) bus.word_in_width = 5'd3;
            if (pv && !pr && (bus.m_word !== pw || bus.m_index !== pi || bus.m_valid !== 1'b1))
                stab_err++;
            if (width_err) werr_cnt++;
            if (bus.m_last !== (bus.m_valid && bus.m_index == 4'd15)) last_err++;
            if (bus.m_valid && r) begin
                if (bus.m_index != 4'(beats)) ord_err++;
                got[bus.m_index] = bus.m_word;
                beats++;
                last_cyc = cyc;
            end
            pv = bus.m_valid; pr = r; pw = bus.m_word; pi = bus.m_index;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.m_ready  = 1'b1;
    endtask

    task automatic clear_exp();
        for (int j = 0; j < 16; j++) exp_w[j] = 32'h0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.m_ready = 1'b1; bus.word_in = '0; bus.word_in_width = '0;
        repeat (3) @(negedge clk);
        checks++; if ({bus.in_ready, bus.m_valid, bus.m_last, width_err} !== 4'b0000) begin errors++;
            $display("FAIL reset_ctrl got=%b want=0000", {bus.in_ready, bus.m_valid, bus.m_last, width_err}); end
        checks++; if ({bus.m_word, bus.m_index, block_count} !== 52'h0) begin errors++;
            $display("FAIL reset_data word=%h idx=%0d cnt=%0d want 0", bus.m_word, bus.m_index, block_count); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready_early got=%b want=0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready_rise got=%b want=1", bus.in_ready); end
    endtask

    task automatic check_block(input string name, input int want_werr);
        for (int j = 0; j < 16; j++) begin
            checks++; if (got[j] !== exp_w[j]) begin errors++;
                $display("FAIL %s M%0d got=%h want=%h", name, j, got[j], exp_w[j]); end
        end
        checks++; if (beats != 16 || ord_err != 0) begin errors++;
            $display("FAIL %s_beats got=%0d order_err=%0d want 16/0", name, beats, ord_err); end
        checks++; if (last_err != 0) begin errors++;
            $display("FAIL %s_last got=%0d bad cycles want=0", name, last_err); end
        checks++; if (werr_cnt != want_werr) begin errors++;
            $display("FAIL %s_width_err got=%0d cycles want=%0d", name, werr_cnt, want_werr); end
        checks++; if (bus.in_ready !== 1'b1 || bus.m_valid !== 1'b0) begin errors++;
            $display("FAIL %s_idle got rdy=%b vld=%b want 1/0", name, bus.in_ready, bus.m_valid); end
        blocks++;
        checks++; if (block_count !== 16'(blocks)) begin errors++;
            $display("FAIL %s_count got=%0d want=%0d", name, block_count, blocks); end
    endtask

    task automatic test_akha();
        send(AKHA, 5'd4);
        collect(0);
        clear_exp(); exp_w[0] = 32'h61686b61; exp_w[1] = 32'h00000080; exp_w[14] = 32'h00000020;
        check_block("akha", 0);
        checks++; if (last_cyc != 16) begin errors++;
            $display("FAIL akha_latency got=%0d want=16", last_cyc); end
    endtask

    task automatic test_empty();
        send(ALPHA, 5'd0);
        collect(0);
        clear_exp(); exp_w[0] = 32'h00000080;
        check_block("empty", 0);
    endtask

    task automatic test_full();
        send(ALPHA, 5'd16);
        collect(0);
        clear_exp(); exp_w[0] = 32'h64636261; exp_w[1] = 32'h68676665; exp_w[2] = 32'h6c6b6a69;
        exp_w[3] = 32'h706f6e6d; exp_w[4] = 32'h00000080; exp_w[14] = 32'h00000080;
        check_block("full", 0);
    endtask

    task automatic test_width_clamp();
        send(ALPHA, 5'd20);
        collect(0);
        clear_exp(); exp_w[0] = 32'h64636261; exp_w[1] = 32'h68676665; exp_w[2] = 32'h6c6b6a69;
        exp_w[3] = 32'h706f6e6d; exp_w[4] = 32'h00000080; exp_w[14] = 32'h00000080;
        check_block("clamp", 1);
    endtask

    task automatic test_stall();
        send(AKHA, 5'd4);
        bus.word_in = ALPHA;
        collect(1);
        clear_exp(); exp_w[0] = 32'h61686b61; exp_w[1] = 32'h00000080; exp_w[14] = 32'h00000020;
        check_block("stall", 0);
        checks++; if (stab_err != 0) begin errors++;
            $display("FAIL stall_stable got=%0d changes want=0", stab_err); end
        checks++; if (last_cyc <= 16) begin errors++;
            $display("FAIL stall_len got=%0d cycles want >16", last_cyc); end
    endtask

    task automatic test_reset_mid();
        int n;
        send(ALPHA, 5'd16);
        n = 0;
        while (bus.m_index != 4'd5 && n < 20) begin @(negedge clk); n++; end
        checks++; if (bus.m_index !== 4'd5 || bus.m_valid !== 1'b1) begin errors++;
            $display("FAIL rst_mid_reach idx=%0d vld=%b want 5/1", bus.m_index, bus.m_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.m_valid !== 1'b0 || bus.m_index !== 4'd0 || bus.m_word !== 32'h0) begin errors++;
            $display("FAIL rst_mid_drop vld=%b idx=%0d word=%h want 0", bus.m_valid, bus.m_index, bus.m_word); end
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || block_count !== 16'd0) begin errors++;
            $display("FAIL rst_mid_release rdy=%b cnt=%0d want 1/0", bus.in_ready, block_count); end
        blocks = 0;
        send(AKHA, 5'd4);
        collect(0);
        clear_exp(); exp_w[0] = 32'h61686b61; exp_w[1] = 32'h00000080; exp_w[14] = 32'h00000020;
        check_block("after_rst", 0);
    endtask

    initial begin
        test_reset();
        test_akha();
        test_empty();
        test_full();
        test_width_clamp();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
